mode_counter: RTL and testbench

Parametrised successor to the team's basic up-counter. Adds:
- up/down counting
- a runtime-programmable terminal value (`limit`)
- synchronous parallel load
- wrap or one-shot mode
- separate sticky overflow/underflow flags and a terminal-count pulse

Sits in the counter_system datapath wherever a software-configurable timer or event counter is needed; controlled directly from register-file bits.

---
 rtl/mode_counter.sv | 104 ++++++++++
 tb/tb_mode_counter.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/mode_counter.sv
// Up/down counter with programmable terminal value, parallel load, wrap or
// one-shot mode, sticky overflow/underflow flags and a registered tc pulse.
module mode_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             res,
  input  logic             enable,
  input  logic             up,
  input  logic             oneshot,
  input  logic [WIDTH-1:0] limit,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             reinit,
  input  logic             clear_flags,
  output logic [WIDTH-1:0] value,
  output logic             overflow,
  output logic             underflow,
  output logic             tc,
  output logic             busy,
  output logic             done
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] value_q, value_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;
  logic             tc_q, tc_d;
  logic             set_ov, set_un;

  always_comb begin
    state_d = state_q;
    value_d = value_q;
    tc_d    = 1'b0;
    set_ov  = 1'b0;
    set_un  = 1'b0;

    if (reinit) begin
      value_d = '0;
      state_d = ST_IDLE;
    end else if (load) begin
      value_d = (load_value > limit) ? limit : load_value;
      if (state_q == ST_DONE) state_d = ST_IDLE;
    end else if (enable && state_q != ST_DONE) begin
      state_d = ST_RUN;
      // Terminal checks precede the add/sub, so the count never wraps modulo 2^WIDTH.
      if (up) begin
        if (value_q >= limit) begin
          set_ov = 1'b1;
          tc_d   = 1'b1;
          if (oneshot) begin
            value_d = limit;
            state_d = ST_DONE;
          end else begin
            value_d = '0;
          end
        end else begin
          value_d = value_q + 1'b1;
        end
      end else begin
        if (value_q == '0) begin
          set_un = 1'b1;
          tc_d   = 1'b1;
          if (oneshot) state_d = ST_DONE;
          else         value_d = limit;
        end else begin
          value_d = value_q - 1'b1;
        end
      end
    end

    // A set event in the same cycle as clear_flags leaves the flag set.
    overflow_d  = (overflow_q  & ~clear_flags) | set_ov;
    underflow_d = (underflow_q & ~clear_flags) | set_un;
  end

  always_ff @(posedge clk) begin
    if (res) begin
      state_q     <= ST_IDLE;
      value_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      tc_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      value_q     <= value_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
      tc_q        <= tc_d;
    end
  end

  assign value     = value_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;
  assign tc        = tc_q;
  assign busy      = (state_q == ST_RUN);
  assign done      = (state_q == ST_DONE);

endmodule

// File: tb/tb_mode_counter.sv
// Self-checking bench for mode_counter: directed scenarios plus randomized
// traffic compared against a behavioural model of the counting rules.
module tb_mode_counter;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         res, enable, up, oneshot, load, reinit, clear_flags;
  logic [W-1:0] limit, load_value;
  logic [W-1:0] value;
  logic         overflow, underflow, tc, busy, done;

  int checks = 0;
  int failures = 0;

  typedef enum {M_IDLE, M_RUN, M_DONE} mstate_t;
  mstate_t mState;
  int      mValue;
  bit      mOv, mUn, mTc;

  mode_counter #(.WIDTH(W)) dut (
    .clk(clk), .res(res), .enable(enable), .up(up), .oneshot(oneshot),
    .limit(limit), .load(load), .load_value(load_value), .reinit(reinit),
    .clear_flags(clear_flags), .value(value), .overflow(overflow),
    .underflow(underflow), .tc(tc), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference model: applies one clock edge using the inputs currently driven.
  function automatic void modelEdge();
    bit setO, setU;
    int lim;
    setO = 0;
    setU = 0;
    lim  = int'(limit);
    if (res) begin
      mState = M_IDLE; mValue = 0; mOv = 0; mUn = 0; mTc = 0;
      return;
    end
    mTc = 0;
    if (reinit) begin
      mValue = 0;
      mState = M_IDLE;
    end else if (load) begin
      mValue = (int'(load_value) > lim) ? lim : int'(load_value);
      if (mState == M_DONE) mState = M_IDLE;
    end else if (enable && mState != M_DONE) begin
      mState = M_RUN;
      if (up) begin
        if (mValue >= lim) begin
          setO = 1; mTc = 1;
          if (oneshot) begin mValue = lim; mState = M_DONE; end
          else mValue = 0;
        end else mValue = mValue + 1;
      end else begin
        if (mValue == 0) begin
          setU = 1; mTc = 1;
          if (oneshot) mState = M_DONE;
          else mValue = lim;
        end else mValue = mValue - 1;
      end
    end
    if (clear_flags) begin mOv = 0; mUn = 0; end
    mOv = mOv | setO;
    mUn = mUn | setU;
  endfunction

  task automatic checkAgainstModel(input string tag);
    checkOutput({tag, "_value"}, 32'(value), 32'(mValue));
    checkOutput({tag, "_ovf"}, 32'(overflow), 32'(mOv));
    checkOutput({tag, "_unf"}, 32'(underflow), 32'(mUn));
    checkOutput({tag, "_tc"}, 32'(tc), 32'(mTc));
    checkOutput({tag, "_busy"}, 32'(busy), 32'(mState == M_RUN));
    checkOutput({tag, "_done"}, 32'(done), 32'(mState == M_DONE));
  endtask

  task automatic applyStimulus(input string tag);
    @(posedge clk);
    modelEdge();
    #1;
    checkAgainstModel(tag);
  endtask

  task automatic quiet();
    res = 0; enable = 0; load = 0; reinit = 0; clear_flags = 0;
  endtask

  initial begin
    logic [W-1:0] seqA [8];
    logic [W-1:0] seqB [6];
    seqA = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd0, 8'd1, 8'd2};
    seqB = '{8'd1, 8'd2, 8'd3, 8'd3, 8'd3, 8'd3};
    mState = M_IDLE; mValue = 0; mOv = 0; mUn = 0; mTc = 0;

    quiet();
    up = 1; oneshot = 0; limit = 8'd5; load_value = 0;
    res = 1;
    applyStimulus("reset");
    checkOutput("reset_value", 32'(value), 0);
    checkOutput("reset_busy", 32'(busy), 0);
    res = 0;

    // Wrap-mode up count with limit 5.
    enable = 1;
    for (int i = 0; i < 8; i++) begin
      applyStimulus("wrap");
      checkOutput("wrap_seq", 32'(value), 32'(seqA[i]));
      checkOutput("wrap_tc", 32'(tc), 32'(i == 5));
    end
    checkOutput("wrap_ovf", 32'(overflow), 1);
    checkOutput("wrap_busy", 32'(busy), 1);

    // One-shot up count with limit 3.
    quiet(); reinit = 1;
    applyStimulus("reinit1");
    quiet(); oneshot = 1; limit = 8'd3; enable = 1;
    for (int i = 0; i < 6; i++) begin
      applyStimulus("oneshot");
      checkOutput("oneshot_seq", 32'(value), 32'(seqB[i]));
      checkOutput("oneshot_done", 32'(done), 32'(i >= 3));
      checkOutput("oneshot_tc", 32'(tc), 32'(i == 3));
    end
    quiet(); reinit = 1;
    applyStimulus("reinit2");
    checkOutput("reinit_value", 32'(value), 0);
    checkOutput("reinit_done", 32'(done), 0);

    // Down step from 0 in wrap mode.
    quiet(); clear_flags = 1;
    applyStimulus("clr0");
    quiet(); up = 0; oneshot = 0; limit = 8'd9; enable = 1;
    applyStimulus("down");
    checkOutput("down_value", 32'(value), 9);
    checkOutput("down_unf", 32'(underflow), 1);
    checkOutput("down_ovf", 32'(overflow), 0);
    quiet(); clear_flags = 1;
    applyStimulus("clr1");
    checkOutput("clr_unf", 32'(underflow), 0);

    // Load clamps to limit and suppresses the step.
    quiet(); load = 1; load_value = 8'd200; limit = 8'd100; enable = 1; up = 1;
    applyStimulus("loadclamp");
    checkOutput("loadclamp_value", 32'(value), 100);
    checkOutput("loadclamp_ovf", 32'(overflow), 0);
    quiet(); oneshot = 1; enable = 1;
    applyStimulus("todone");
    checkOutput("todone_done", 32'(done), 1);
    quiet(); load = 1; load_value = 8'd5;
    applyStimulus("loaddone");
    checkOutput("loaddone_value", 32'(value), 5);
    checkOutput("loaddone_done", 32'(done), 0);

    // Terminal event together with clear_flags: set wins.
    quiet(); oneshot = 0; limit = 8'd0; enable = 1; clear_flags = 1;
    applyStimulus("setwins");
    checkOutput("setwins_ovf", 32'(overflow), 1);
    applyStimulus("lim0b");
    checkOutput("lim0_tc_held", 32'(tc), 1);

    // reinit beats load; res beats everything.
    quiet(); reinit = 1; load = 1; load_value = 8'd7; limit = 8'd50;
    applyStimulus("reinitload");
    checkOutput("reinitload_value", 32'(value), 0);
    quiet(); res = 1; load = 1; enable = 1;
    applyStimulus("resload");
    checkOutput("resload_value", 32'(value), 0);
    checkOutput("resload_ovf", 32'(overflow), 0);

    // Lowering limit below the current value while counting up.
    quiet(); limit = 8'd10; load = 1; load_value = 8'd7;
    applyStimulus("pre_lower");
    quiet(); limit = 8'd4; up = 1; oneshot = 0; enable = 1;
    applyStimulus("lower");
    checkOutput("lower_value", 32'(value), 0);
    checkOutput("lower_ovf", 32'(overflow), 1);
    checkOutput("lower_tc", 32'(tc), 1);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      res         = ($urandom_range(0, 99) == 0);
      reinit      = ($urandom_range(0, 39) == 0);
      load        = ($urandom_range(0, 19) == 0);
      clear_flags = ($urandom_range(0, 15) == 0);
      enable      = ($urandom_range(0, 3) != 0);
      up          = ($urandom_range(0, 99) < 60);
      oneshot     = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 15) == 0)
        limit = ($urandom_range(0, 3) == 0) ? W'($urandom) : W'($urandom_range(0, 12));
      load_value = ($urandom_range(0, 1) == 1) ? W'($urandom) : W'($urandom_range(0, 15));
      applyStimulus("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
